// File: rtl/cmd_cfg_mc.sv
// Quadcopter command configurator: decodes UART opcodes into attitude/thrust setpoints and sequences inertial calibration.
// Also provides a calibration timeout, negative acknowledge, a thrust ceiling, a link watchdog and a ramped landing.
module cmd_cfg_mc #(
    parameter bit FAST_SIM  = 1'b1,
    parameter int DATA_W    = 16,
    parameter int THRST_W   = 9,
    parameter int THRST_MAX = 400,
    parameter int CAL_TO_W  = 12,
    parameter int WDOG_W    = 20,
    parameter int RAMP_W    = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cmd_rdy_i,
    input  logic [7:0]               cmd_i,
    input  logic [DATA_W-1:0]        data_i,
    input  logic                     cal_done_i,
    output logic                     clr_cmd_rdy_o,
    output logic [7:0]               resp_o,
    output logic                     send_resp_o,
    output logic signed [DATA_W-1:0] d_ptch_o,
    output logic signed [DATA_W-1:0] d_roll_o,
    output logic signed [DATA_W-1:0] d_yaw_o,
    output logic [THRST_W-1:0]       thrst_o,
    output logic                     strt_cal_o,
    output logic                     inertial_cal_o,
    output logic                     motors_off_o,
    output logic                     landing_o,
    output logic                     wdog_trip_o
);
    localparam logic [7:0] OP_PTCH  = 8'h02;
    localparam logic [7:0] OP_ROLL  = 8'h03;
    localparam logic [7:0] OP_YAW   = 8'h04;
    localparam logic [7:0] OP_THRST = 8'h05;
    localparam logic [7:0] OP_CAL   = 8'h06;
    localparam logic [7:0] OP_LAND  = 8'h07;
    localparam logic [7:0] OP_OFF   = 8'h08;
    localparam logic [7:0] POS_ACK  = 8'hA5;
    localparam logic [7:0] NEG_ACK  = 8'hEE;
    localparam int         TMR_W    = 25;
    localparam logic [THRST_W-1:0] THRST_CEIL = THRST_W'(THRST_MAX);

    typedef enum logic [1:0] {IDLE, WAIT, CAL, ACK} state_t;

    state_t                   state_q, state_d;
    logic [TMR_W-1:0]         tmr_q, tmr_d;
    logic [WDOG_W-1:0]        wdog_q, wdog_d;
    logic [RAMP_W-1:0]        ramp_q, ramp_d;
    logic signed [DATA_W-1:0] ptch_q, ptch_d, roll_q, roll_d, yaw_q, yaw_d;
    logic [THRST_W-1:0]       thrst_q, thrst_d, data_thrst;
    logic [7:0]               resp_q, resp_d;
    logic                     motors_off_q, motors_off_d;
    logic                     landing_q, landing_d;
    logic                     wdog_trip_q, wdog_trip_d;
    logic                     accept, wait_done, cal_to, wdog_run, wdog_exp;

    assign wait_done  = FAST_SIM ? (&tmr_q[8:0]) : (&tmr_q);
    assign cal_to     = &tmr_q[CAL_TO_W-1:0];
    assign accept     = (state_q == IDLE) && cmd_rdy_i;
    assign wdog_run   = (state_q == IDLE) && !motors_off_q;
    assign wdog_exp   = wdog_run && (&wdog_q);
    assign data_thrst = data_i[THRST_W-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_rdy_i) state_d = (cmd_i == OP_CAL) ? WAIT : ACK;
            WAIT:    if (wait_done) state_d = CAL;
            CAL:     if (cal_done_i || cal_to) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        clr_cmd_rdy_o  = 1'b0;
        strt_cal_o     = 1'b0;
        inertial_cal_o = 1'b0;
        send_resp_o    = 1'b0;
        case (state_q)
            IDLE: clr_cmd_rdy_o = cmd_rdy_i;
            WAIT: begin
                inertial_cal_o = 1'b1;
                strt_cal_o     = wait_done;
            end
            CAL:  inertial_cal_o = 1'b1;
            ACK:  send_resp_o = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        tmr_d        = '0;
        wdog_d       = wdog_q;
        ramp_d       = '0;
        ptch_d       = ptch_q;
        roll_d       = roll_q;
        yaw_d        = yaw_q;
        thrst_d      = thrst_q;
        resp_d       = resp_q;
        motors_off_d = motors_off_q;
        landing_d    = landing_q;
        wdog_trip_d  = wdog_trip_q;

        // One timer serves both the WAIT delay and the CAL timeout; it restarts on entry to CAL.
        if ((state_q == WAIT && !wait_done) || state_q == CAL) tmr_d = tmr_q + 1'b1;
        if (wdog_run) wdog_d = wdog_q + 1'b1;

        if (landing_q) begin
            if (thrst_q == '0) begin
                landing_d = 1'b0;
            end else begin
                ramp_d = ramp_q + 1'b1;
                if (&ramp_q) thrst_d = thrst_q - 1'b1;
            end
        end

        if (state_q == CAL) begin
            if (cal_done_i) begin
                resp_d = POS_ACK;
            end else if (cal_to) begin
                resp_d       = NEG_ACK;
                motors_off_d = 1'b1;
            end
        end

        // A command arriving on the expiry cycle takes priority over the watchdog.
        if (accept) begin
            wdog_d      = '0;
            wdog_trip_d = 1'b0;
            if (cmd_i != OP_CAL) resp_d = POS_ACK;
            case (cmd_i)
                OP_PTCH:  ptch_d = data_i;
                OP_ROLL:  roll_d = data_i;
                OP_YAW:   yaw_d  = data_i;
                OP_THRST: begin
                    thrst_d   = (data_thrst > THRST_CEIL) ? THRST_CEIL : data_thrst;
                    landing_d = 1'b0;
                end
                OP_CAL:   motors_off_d = 1'b0;
                OP_LAND:  begin
                    ptch_d    = '0;
                    roll_d    = '0;
                    yaw_d     = '0;
                    landing_d = 1'b1;
                end
                OP_OFF:   begin
                    motors_off_d = 1'b1;
                    thrst_d      = '0;
                    landing_d    = 1'b0;
                end
                default:  resp_d = NEG_ACK;
            endcase
        end else if (wdog_exp) begin
            ptch_d      = '0;
            roll_d      = '0;
            yaw_d       = '0;
            landing_d   = 1'b1;
            wdog_trip_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmr_q        <= '0;
            wdog_q       <= '0;
            ramp_q       <= '0;
            ptch_q       <= '0;
            roll_q       <= '0;
            yaw_q        <= '0;
            thrst_q      <= '0;
            resp_q       <= 8'h00;
            motors_off_q <= 1'b1;
            landing_q    <= 1'b0;
            wdog_trip_q  <= 1'b0;
        end else begin
            tmr_q        <= tmr_d;
            wdog_q       <= wdog_d;
            ramp_q       <= ramp_d;
            ptch_q       <= ptch_d;
            roll_q       <= roll_d;
            yaw_q        <= yaw_d;
            thrst_q      <= thrst_d;
            resp_q       <= resp_d;
            motors_off_q <= motors_off_d;
            landing_q    <= landing_d;
            wdog_trip_q  <= wdog_trip_d;
        end
    end

    assign resp_o       = resp_q;
    assign d_ptch_o     = ptch_q;
    assign d_roll_o     = roll_q;
    assign d_yaw_o      = yaw_q;
    assign thrst_o      = thrst_q;
    assign motors_off_o = motors_off_q;
    assign landing_o    = landing_q;
    assign wdog_trip_o  = wdog_trip_q;

endmodule
